// File: rtl/e_multi_seq.sv
// e_multi_seq: sequential schoolbook multiplier producing one 16x16 partial product per clock.
// Multiplies two 16*WORDS-bit operands into a 32*WORDS-bit product with valid/ready on both sides.
module e_multi_seq #(
    parameter int WORDS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in_a,
    input  logic [16*WORDS-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   out_data,
    output logic                  busy
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t              r_state, w_next;
    logic [IW-1:0]       r_i, r_j;
    logic [16*WORDS-1:0] r_a, r_b;
    logic [32*WORDS-1:0] r_acc;
    logic [15:0]         r_carry;
    logic [31:0]         w_t;
    logic [IW:0]         w_k;
    logic                w_last_i, w_last, w_accept;

    assign w_k      = {1'b0, r_i} + {1'b0, r_j};
    assign w_last_i = (r_i == IW'(WORDS - 1));
    assign w_last   = w_last_i && (r_j == IW'(WORDS - 1));
    assign w_accept = (r_state == IDLE) && in_valid;
    // a[i]*b[j] + acc[i+j] + carry peaks at 2^32-1, so 32 bits are exact
    assign w_t = 32'(r_a[16*r_i +: 16]) * 32'(r_b[16*r_j +: 16])
               + 32'(r_acc[16*w_k +: 16]) + 32'(r_carry);

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_acc;

    always_comb begin
        w_next = r_state;
        if (w_accept)
            w_next = MUL;
        if (r_state == MUL && w_last)
            w_next = DONE;
        if (r_state == DONE && out_ready)
            w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= '0;
            r_i     <= '0;
            r_j     <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_acc   <= '0;
            r_carry <= '0;
            r_i     <= '0;
            r_j     <= '0;
        end else if (r_state == MUL) begin
            r_acc[16*w_k +: 16] <= w_t[15:0];
            if (w_last_i) begin
                // top word of this row has never been written by earlier rows
                r_acc[16*(int'(r_j) + WORDS) +: 16] <= w_t[31:16];
                r_carry <= '0;
                r_i     <= '0;
                r_j     <= w_last ? '0 : r_j + 1'b1;
            end else begin
                r_carry <= w_t[31:16];
                r_i     <= r_i + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_e_multi_seq.sv
// tb_e_multi_seq: random and directed checks of e_multi_seq against a latency/product model.
// A WORDS=2 instance takes the directed cases; WORDS 1, 4 and 32 instances run random pairs.
module tb_e_multi_seq;
    logic clk = 0, rst = 0, rst2 = 0;
    always #5 clk = ~clk;

    logic        in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid, busy;
    logic [31:0] in_a = 0, in_b = 0;
    logic [63:0] out_data;
    int          tests = 0, fails = 0;

    task automatic chk(input string nm, input bit ok, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    e_multi_seq #(.WORDS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    // model: phase 0 idle, 1 computing for W*W edges, 2 product held until taken
    int          ph = 0, cnt = 0, outs = 0;
    logic [63:0] mexp = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph  <= 0;
            cnt <= 0;
        end else if (ph == 0) begin
            if (in_valid) begin
                ph   <= 1;
                cnt  <= 4;
                mexp <= 64'(in_a) * 64'(in_b);
            end
        end else if (ph == 1) begin
            cnt <= cnt - 1;
            if (cnt == 1) ph <= 2;
        end else if (out_ready) begin
            ph   <= 0;
            outs <= outs + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("hs_w2", {in_ready, out_valid, busy} == {ph == 0, ph == 2, ph != 0},
                256'({in_ready, out_valid, busy}), 256'({ph == 0, ph == 2, ph != 0}));
            if (ph == 2)
                chk("data_w2", out_data == mexp, 256'(out_data), 256'(mexp));
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gw
        localparam int W  = (g == 0) ? 1 : (g == 1) ? 4 : 32;
        localparam int PW = 32 * W;
        localparam int N  = (g == 0) ? 300 : (g == 1) ? 150 : 16;
        logic          iv = 0, orr = 1, ir, ov, bz;
        logic [16*W-1:0] ia = '0, ib = '0;
        logic [PW-1:0] od, mx = '0;
        int            mph = 0, mcnt = 0, mouts = 0;
        bit            done = 0;

        e_multi_seq #(.WORDS(W)) u (
            .clk(clk), .rst(rst2), .in_valid(iv), .in_ready(ir),
            .in_a(ia), .in_b(ib), .out_valid(ov), .out_ready(orr),
            .out_data(od), .busy(bz)
        );

        always @(posedge clk or posedge rst2) begin
            if (rst2) begin
                mph  <= 0;
                mcnt <= 0;
            end else if (mph == 0) begin
                if (iv) begin
                    mph  <= 1;
                    mcnt <= W * W;
                    mx   <= PW'(ia) * PW'(ib);
                end
            end else if (mph == 1) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) mph <= 2;
            end else if (orr) begin
                mph   <= 0;
                mouts <= mouts + 1;
            end
        end

        always @(negedge clk) begin
            if (!rst2) begin
                chk($sformatf("hs_w%0d", W), {ir, ov, bz} == {mph == 0, mph == 2, mph != 0},
                    256'({ir, ov, bz}), 256'({mph == 0, mph == 2, mph != 0}));
                if (mph == 2)
                    chk($sformatf("data_w%0d", W), od == mx, 256'(od), 256'(mx));
            end
        end

        initial begin
            int base, n, sel;
            wait (rst2 == 1);
            wait (rst2 == 0);
            for (int k = 0; k < N; k++) begin
                @(negedge clk);
                for (int w = 0; w < W; w++) begin
                    ia[16*w +: 16] = 16'($urandom);
                    ib[16*w +: 16] = 16'($urandom);
                end
                sel = $urandom % 8;
                if (sel == 0 || sel == 2) ia = '1;
                if (sel == 1) ib = '0;
                if (sel == 2) ib = '1;
                iv   = 1;
                base = mouts;
                @(posedge clk);
                #1 iv = 0;
                ia = '1;
                ib = '1;
                n = 0;
                while (mouts == base && n < W * W + 300) begin
                    @(negedge clk);
                    orr = ($urandom % 3) != 0;
                    n++;
                end
                chk($sformatf("done_w%0d", W), mouts != base, 256'(mouts), 256'(base + 1));
                orr = 1;
            end
            done = 1;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit hold);
        int n = 0;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", in_ready, 256'(in_ready), 256'(1));
        @(posedge clk);
        #1 in_valid = hold;
        in_a = $urandom;
        in_b = $urandom;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 2000) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    initial begin
        int n, base, sel;
        logic [63:0] d;
        logic [31:0] a, b;
        #2 rst = 1;
        rst2 = 1;
        #1 chk("reset_state", {in_ready, out_valid, busy} == 3'b100 && out_data == 0,
               256'({in_ready, out_valid, busy, out_data}), 256'({3'b100, 64'h0}));
        repeat (2) @(negedge clk);
        rst = 0;
        rst2 = 0;

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
            chk("max_in_ready_low", !in_ready, 256'(in_ready), 256'(0));
        end
        chk("max_latency", n == 4, 256'(n), 256'(4));
        chk("max_data", out_data == 64'hFFFF_FFFE_0000_0001, 256'(out_data), 256'(64'hFFFF_FFFE_0000_0001));
        chk("max_model", mexp == 64'hFFFF_FFFE_0000_0001, 256'(mexp), 256'(64'hFFFF_FFFE_0000_0001));

        send(32'h1234_5678, 32'h0, 0);
        wait_valid(n);
        chk("times_zero", out_data == 64'h0 && n == 4, 256'({n, out_data}), 256'({32'd4, 64'h0}));
        send(32'h1234_5678, 32'h1, 0);
        wait_valid(n);
        chk("times_one", out_data == 64'h1234_5678, 256'(out_data), 256'(64'h1234_5678));

        send(32'h0002_0003, 32'h0004_0005, 0);
        out_ready = 0;
        wait_valid(n);
        d = out_data;
        chk("bp_product", d == 64'h0000_0008_0016_000F, 256'(d), 256'(64'h0000_0008_0016_000F));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_a = $urandom;
            in_b = $urandom;
            @(posedge clk);
            #1 chk("bp_hold", out_valid && !in_ready && out_data == d,
                   256'({out_valid, in_ready, out_data}), 256'({2'b10, d}));
        end
        @(negedge clk);
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1 chk("bp_release", in_ready && !out_valid, 256'({in_ready, out_valid}), 256'(2'b10));

        send(32'hFFFF_FFFF, 32'h1234_5678, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1 chk("rst_async", in_ready && !out_valid && !busy && out_data == 0,
               256'({in_ready, out_valid, busy, out_data}), 256'({3'b100, 64'h0}));
        @(negedge clk);
        rst = 0;
        send(32'd3, 32'd5, 0);
        wait_valid(n);
        chk("after_rst", out_data == 64'd15 && n == 4, 256'({n, out_data}), 256'({32'd4, 64'd15}));

        @(posedge clk);
        #1 base = outs;
        send(32'h0000_0007, 32'h0000_0006, 1);
        send(32'hFFFF_0000, 32'h0001_0001, 1);
        send(32'h0001_0000, 32'h0001_0000, 0);
        wait_valid(n);
        chk("b2b_last", out_data == 64'h1_0000_0000, 256'(out_data), 256'(64'h1_0000_0000));
        @(posedge clk);
        #1 chk("b2b_count", outs == base + 3, 256'(outs), 256'(base + 3));

        for (int k = 0; k < 300; k++) begin
            a = $urandom;
            b = $urandom;
            sel = $urandom % 8;
            if (sel == 0) a = '1;
            if (sel == 1) b = '0;
            if (sel == 2) b = 32'd1;
            base = outs;
            send(a, b, 0);
            n = 0;
            while (outs == base && n < 300) begin
                @(negedge clk);
                out_ready = ($urandom % 3) != 0;
                n++;
            end
            chk("rand_done_w2", outs != base, 256'(outs), 256'(base + 1));
            out_ready = 1;
        end

        n = 0;
        while (!(gw[0].done && gw[1].done && gw[2].done) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("sub_done", gw[0].done && gw[1].done && gw[2].done,
            256'({gw[0].done, gw[1].done, gw[2].done}), 256'(3'b111));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
